tri_bus_transceiver: RTL and testbench

- Half-duplex endpoint for a shared W-bit tri-state parallel bus. It is the counterpart to the team's tri-state output buffers.
- Owns the bus driver: it enables its drivers only while it sends a word, and otherwise releases the bus and captures words driven by a same-clock peer.
- Inserts turnaround gaps so two ends never drive the bus at the same time.
- Sits between local logic (valid/ready send, valid-pulse receive) and the board-level bidirectional pins.

---
 rtl/tri_bus_transceiver_if.sv | 29 ++
 rtl/tri_bus_transceiver.sv | 124 ++++++++++++
 tb/tb_tri_bus_transceiver.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tri_bus_transceiver_if.sv
// Local-side signal bundle of the tri-state bus transceiver: send handshake,
// receive pulse, strobes to/from the peer, drive enable and collision flag.
// The bidirectional pins themselves stay a plain inout port on the block.
interface tri_bus_transceiver_if #(
    parameter int W = 8
);
    logic         tx_valid;
    logic [W-1:0] tx_data;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         strb_o;
    logic         strb_i;
    logic         oe;
    logic         err;
    logic         err_clr;

    // Transceiver side
    modport slave (
        input  tx_valid, tx_data, strb_i, err_clr,
        output tx_ready, rx_data, rx_valid, strb_o, oe, err
    );

    // Local logic / peer side
    modport master (
        output tx_valid, tx_data, strb_i, err_clr,
        input  tx_ready, rx_data, rx_valid, strb_o, oe, err
    );
endinterface

// File: rtl/tri_bus_transceiver.sv
// Half-duplex endpoint for a shared tri-state parallel bus. Sends one word
// per handshake framed by turnaround gaps (TURN_ON / DRIVE / TURN_OFF), and
// captures peer words on a rising peer strobe while idle. A peer strobe seen
// while this end owns the send sequence raises a sticky collision flag.
module tri_bus_transceiver #(
    parameter int W    = 8,
    parameter int TURN = 1,
    parameter int HOLD = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tri_bus_transceiver_if.slave   bus_if,
    inout  wire  [W-1:0]           bus_io
);
    localparam int MAXC = (TURN > HOLD) ? TURN : HOLD;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] TURN_LD = CW'(TURN - 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        TURN_ON,
        DRIVE,
        TURN_OFF
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  word_q;
    logic [W-1:0]  rx_data_q;
    logic          rx_valid_q;
    logic          strb_i_q;
    logic          oe_q;
    logic          strb_o_q;
    logic          err_q;
    logic          cnt_zero;
    logic          strb_rise;
    logic          tx_ready;

    assign cnt_zero  = (cnt_q == '0);
    assign strb_rise = bus_if.strb_i & ~strb_i_q;
    // A peer strobe blocks acceptance so a receive always wins over a send.
    assign tx_ready  = (state_q == IDLE) & ~bus_if.strb_i;

    assign bus_if.tx_ready = tx_ready;
    assign bus_if.rx_data  = rx_data_q;
    assign bus_if.rx_valid = rx_valid_q;
    assign bus_if.strb_o   = strb_o_q;
    assign bus_if.oe       = oe_q;
    assign bus_if.err      = err_q;

    // Pins are driven only from the registered enable, so reset releases them at once.
    assign bus_io = oe_q ? word_q : {W{1'bz}};

    // Send sequencer, receive capture and collision flag; oe/strb_o decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            strb_i_q   <= 1'b0;
            oe_q       <= 1'b0;
            strb_o_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            strb_i_q   <= bus_if.strb_i;
            rx_valid_q <= 1'b0;

            // A collision on the same edge as err_clr keeps the flag set.
            if ((state_q != IDLE) && bus_if.strb_i) begin
                err_q <= 1'b1;
            end else if (bus_if.err_clr) begin
                err_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (strb_rise) begin
                        rx_data_q  <= bus_io;
                        rx_valid_q <= 1'b1;
                    end else if (bus_if.tx_valid && tx_ready) begin
                        word_q  <= bus_if.tx_data;
                        cnt_q   <= TURN_LD;
                        state_q <= TURN_ON;
                    end
                end
                TURN_ON: begin
                    if (cnt_zero) begin
                        cnt_q    <= HOLD_LD;
                        state_q  <= DRIVE;
                        oe_q     <= 1'b1;
                        strb_o_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt_zero) begin
                        cnt_q    <= TURN_LD;
                        state_q  <= TURN_OFF;
                        oe_q     <= 1'b0;
                        strb_o_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                TURN_OFF: begin
                    if (cnt_zero) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    oe_q     <= 1'b0;
                    strb_o_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tri_bus_transceiver.sv
// Bench for tri_bus_transceiver: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a transaction-level model.
module tb_tri_bus_transceiver;
    localparam int W    = 8;
    localparam int TURN = 1;
    localparam int HOLD = 2;
    localparam int SEQ  = 2 * TURN + HOLD;

    logic         clk;
    logic         rst_n;
    logic         peer_oe;
    logic [W-1:0] peer_data;
    wire  [W-1:0] bus;

    int tests = 0;
    int fails = 0;

    tri_bus_transceiver_if #(.W(W)) bif ();

    assign bus = peer_oe ? peer_data : {W{1'bz}};

    tri_bus_transceiver #(.W(W), .TURN(TURN), .HOLD(HOLD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bif),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         tv;
        logic [W-1:0] td;
        logic         si;
        logic [W-1:0] pd;
        logic         rdy;
        logic         oe;
        logic [W-1:0] bv;
        logic         rv;
        logic [W-1:0] rd;
    } vec_t;

    vec_t tbl [0:16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic tv, input logic [W-1:0] td, input logic si,
                          input logic poe, input logic [W-1:0] pd, input logic clr);
        bif.tx_valid = tv;
        bif.tx_data  = td;
        bif.strb_i   = si;
        peer_oe      = poe;
        peer_data    = pd;
        bif.err_clr  = clr;
    endtask

    task automatic do_reset();
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Transaction-level reference: the send window is pure arithmetic on edges since accept.
    int           e;
    int           acc;
    logic [W-1:0] m_word;
    logic [W-1:0] m_rd;
    logic         m_rv;
    logic         m_err;
    logic         m_sq;

    function automatic logic m_busy(input int edge_n, input int acc_n);
        return (edge_n - acc_n >= 1) && (edge_n - acc_n <= SEQ);
    endfunction

    function automatic logic m_oe(input int edge_n, input int acc_n);
        return (edge_n - acc_n >= TURN) && (edge_n - acc_n <= TURN + HOLD - 1);
    endfunction

    initial begin
        logic b;
        logic tv, si, clr;
        logic [W-1:0] td, pd;
        int a1, a2;
        logic oe_h [0:11];
        logic [W-1:0] bus_h [0:11];

        rst_n = 1'b1;
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_oe", 32'(bif.oe), 0);
        chk("reset_strb_o", 32'(bif.strb_o), 0);
        chk("reset_rx_valid", 32'(bif.rx_valid), 0);
        chk("reset_rx_data", 32'(bif.rx_data), 0);
        chk("reset_err", 32'(bif.err), 0);
        chk("reset_tx_ready", 32'(bif.tx_ready), 1);
        tick();
        rst_n = 1'b1;
        tick();

        // Single send, receive of a 3-cycle strobe, then send vs strobe-rise on one edge.
        tbl[0]  = '{1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b1, 8'hC3};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, 8'hC3};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, 8'hC3};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'hC3};
        tbl[10] = '{1'b1, 8'h77, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b1, 8'h5A};
        tbl[11] = '{1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h5A};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b0, 8'h5A};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b0, 8'h5A};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h5A};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h5A};
        tbl[16] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h5A};

        for (int i = 0; i <= 16; i++) begin
            set_in(tbl[i].tv, tbl[i].td, tbl[i].si, tbl[i].si, tbl[i].pd, 1'b0);
            #1;
            chk($sformatf("vec%0d_tx_ready", i), 32'(bif.tx_ready), 32'(tbl[i].rdy));
            tick();
            chk($sformatf("vec%0d_oe", i), 32'(bif.oe), 32'(tbl[i].oe));
            chk($sformatf("vec%0d_strb_o", i), 32'(bif.strb_o), 32'(tbl[i].oe));
            chk($sformatf("vec%0d_rx_valid", i), 32'(bif.rx_valid), 32'(tbl[i].rv));
            chk($sformatf("vec%0d_rx_data", i), 32'(bif.rx_data), 32'(tbl[i].rd));
            if (tbl[i].oe) chk($sformatf("vec%0d_bus", i), 32'(bus), 32'(tbl[i].bv));
        end

        // Reset asserted while driving releases the bus without a clock edge.
        do_reset();
        set_in(1'b1, 8'hA5, 1'b0, 1'b0, '0, 1'b0);
        tick();
        bif.tx_valid = 1'b0;
        tick();
        chk("rst_mid_oe_before", 32'(bif.oe), 1);
        chk("rst_mid_bus_before", 32'(bus), 32'h0A5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_oe", 32'(bif.oe), 0);
        chk("rst_mid_strb_o", 32'(bif.strb_o), 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_mid_idle_ready", 32'(bif.tx_ready), 1);
        tick();
        chk("rst_mid_oe_after", 32'(bif.oe), 0);

        // Collision during DRIVE, then clear, then clear coinciding with a collision.
        do_reset();
        set_in(1'b1, 8'h11, 1'b0, 1'b0, '0, 1'b0);
        tick();
        bif.tx_valid = 1'b0;
        tick();
        bif.strb_i = 1'b1;
        tick();
        chk("coll_err", 32'(bif.err), 1);
        chk("coll_no_rx", 32'(bif.rx_valid), 0);
        chk("coll_oe_cont", 32'(bif.oe), 1);
        chk("coll_bus_cont", 32'(bus), 32'h011);
        bif.strb_i = 1'b0;
        tick();
        chk("coll_oe_off", 32'(bif.oe), 0);
        tick();
        #1;
        chk("coll_idle_ready", 32'(bif.tx_ready), 1);
        bif.err_clr = 1'b1;
        tick();
        chk("coll_err_cleared", 32'(bif.err), 0);
        bif.err_clr = 1'b0;
        set_in(1'b1, 8'h22, 1'b0, 1'b0, '0, 1'b0);
        tick();
        bif.tx_valid = 1'b0;
        tick();
        bif.strb_i  = 1'b1;
        bif.err_clr = 1'b1;
        tick();
        chk("coll_clr_same_edge", 32'(bif.err), 1);
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        tick();

        // Back-to-back sends with tx_valid held high.
        do_reset();
        set_in(1'b1, 8'h01, 1'b0, 1'b0, '0, 1'b0);
        a1 = -1;
        a2 = -1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (bif.tx_valid && bif.tx_ready) begin
                if (a1 < 0) a1 = c;
                else if (a2 < 0) a2 = c;
            end
            tick();
            if (a1 >= 0) bif.tx_data = 8'h02;
            if (a2 >= 0) bif.tx_valid = 1'b0;
            oe_h[c]  = bif.oe;
            bus_h[c] = bus;
        end
        chk("b2b_first_accept", 32'(a1), 0);
        chk("b2b_accept_gap", 32'(a2 - a1), 32'(SEQ + 1));
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("b2b_oe_%0d", c), 32'(oe_h[c]),
                32'(m_oe(c, 0) || m_oe(c, SEQ + 1)));
            if (m_oe(c, 0)) chk($sformatf("b2b_bus_%0d", c), 32'(bus_h[c]), 32'h01);
            if (m_oe(c, SEQ + 1)) chk($sformatf("b2b_bus_%0d", c), 32'(bus_h[c]), 32'h02);
        end

        // Randomized traffic against the reference model.
        do_reset();
        e = 0; acc = -1000; m_word = '0; m_rd = '0; m_rv = 1'b0; m_err = 1'b0; m_sq = 1'b0;
        for (int n = 0; n < 600; n++) begin
            tv  = 1'($urandom_range(0, 1));
            td  = W'($urandom);
            si  = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 9) == 0);
            pd  = W'($urandom);
            b   = m_busy(e, acc);
            set_in(tv, td, si, si & ~b, pd, clr);
            #1;
            chk("rnd_tx_ready", 32'(bif.tx_ready), 32'(!b && !si));
            m_rv = 1'b0;
            if (!b && si && !m_sq) begin
                m_rd = pd;
                m_rv = 1'b1;
            end else if (!b && tv && !si) begin
                acc    = e;
                m_word = td;
            end
            if (b && si) m_err = 1'b1;
            else if (clr) m_err = 1'b0;
            m_sq = si;
            tick();
            chk("rnd_oe", 32'(bif.oe), 32'(m_oe(e, acc)));
            chk("rnd_strb_o", 32'(bif.strb_o), 32'(m_oe(e, acc)));
            chk("rnd_rx_valid", 32'(bif.rx_valid), 32'(m_rv));
            chk("rnd_rx_data", 32'(bif.rx_data), 32'(m_rd));
            chk("rnd_err", 32'(bif.err), 32'(m_err));
            if (m_oe(e, acc)) chk("rnd_bus", 32'(bus), 32'(m_word));
            e++;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
